// File: rtl/rdptr_fwft.sv
// rtl/rdptr_fwft.sv - read pointer and first-word-fall-through output stage of the async FIFO
// Optional almost-empty flag is built when RDPTR_FWFT_ALMOST_EMPTY_EN is defined.
module rdptr_fwft #(
  parameter int N         = 8,
  parameter int depth     = 90,
  parameter int W         = 8,
  parameter int AE_THRESH = 4
) (
  input  logic         rd_clk,
  input  logic         rd_rst_n,
  input  logic [N-1:0] wr_ptr,
  output logic [N-1:0] rd_ptr,
  output logic         mem_ren,
  output logic [N-2:0] mem_raddr,
  input  logic [W-1:0] mem_rdata,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         fifo_Empty,
  output logic [N-1:0] level
`ifdef RDPTR_FWFT_ALMOST_EMPTY_EN
  ,
  output logic         fifo_Almost_Empty
`endif
);

  localparam logic [N-2:0] LAST_IDX = (N-1)'(depth - 1);
  localparam logic [N:0]   DEPTH_X  = (N+1)'(depth);

  logic [N-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]   occ_q, occ_d;
  logic         inflight_q, inflight_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         pop;
  logic [N:0]   level_x;
  logic         level_unused;

  assign rd_ptr     = rd_ptr_q;
  assign mem_raddr  = rd_ptr_q[N-2:0];
  assign dout       = head_q;
  assign dout_valid = (occ_q != 2'd0);
  assign pop        = dout_valid & dout_ready;
  assign fifo_Empty = (rd_ptr_q == wr_ptr);

  // Differing wrap flags mean the writer is one lap ahead, so add a full depth back.
  always_comb begin
    level_x = {2'b00, wr_ptr[N-2:0]} - {2'b00, rd_ptr_q[N-2:0]};
    if (wr_ptr[N-1] != rd_ptr_q[N-1]) begin
      level_x = level_x + DEPTH_X;
    end
  end

  assign level        = level_x[N-1:0];
  assign level_unused = level_x[N];

  assign mem_ren = !fifo_Empty &
                   ((({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2) | pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (mem_ren) begin
      if (rd_ptr_q[N-2:0] == LAST_IDX) begin
        rd_ptr_d = {~rd_ptr_q[N-1], {(N-1){1'b0}}};
      end else begin
        rd_ptr_d = rd_ptr_q + N'(1);
      end
    end
  end

  // occ + inflight never exceeds 2, so a return can never arrive while both entries are full.
  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    occ_d      = occ_q;
    inflight_d = mem_ren;
    if (pop) begin
      if (occ_q == 2'd2) begin
        head_d = skid_q;
      end
      occ_d = occ_q - 2'd1;
    end
    if (inflight_q) begin
      if (occ_d == 2'd0) begin
        head_d = mem_rdata;
      end else begin
        skid_d = mem_rdata;
      end
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr_q   <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

`ifdef RDPTR_FWFT_ALMOST_EMPTY_EN
  assign fifo_Almost_Empty = (level <= N'(AE_THRESH));
`else
  logic [31:0] ae_thresh_unused;
  assign ae_thresh_unused = AE_THRESH;
`endif

endmodule
